pagewb: RTL and testbench
=========================

PAGEWB -- requirements
Module: pagewb

Interface
REQ-001 Parameters SHALL be: C_M_AXI_THREAD_ID_WIDTH, default 1, AXI ID width; C_M_AXI_ADDR_WIDTH, default 32, address width; C_M_AXI_DATA_WIDTH, default 32, data width (only 32 supported); C_M_AXI_AWUSER_WIDTH, default 1; C_M_AXI_WUSER_WIDTH, default 1; C_M_AXI_BUSER_WIDTH, default 1.
REQ-002 CLK  in  1  clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  one-cycle request to write back one 4 KB page.
REQ-005 PAGE_ADDR  in  20  page number; the DRAM base is {PAGE_ADDR, 12'b0}.
REQ-006 BUSY  out  1  write-back in progress.
REQ-007 DONE  out  1  one-cycle pulse when the whole page has been written.
REQ-008 ERR  out  1  sticky flag: some BRESP was not OKAY during the current or last page.
REQ-009 BRAM_ADDR  out  12  byte address into the local 4 KB page BRAM; bits [1:0] are always 0.
REQ-010 BRAM_DOUT  in  32  BRAM read data, valid one cycle after BRAM_ADDR.
REQ-011 AXI AW channel: M_AXI_AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK[2], AWCACHE, AWPROT, AWQOS, AWUSER, AWVALID out; AWREADY in.
REQ-012 AXI W channel: M_AXI_WDATA[32], WSTRB[4], WLAST, WUSER, WVALID out; WREADY in.
REQ-013 AXI B channel: M_AXI_BID, BRESP[2], BUSER, BVALID in; BREADY out.

Function
REQ-014 The AXI constant outputs SHALL be: AWID=0, AWLEN=8'h1f, AWSIZE=3'b010, AWBURST=2'b01, AWLOCK=0, AWCACHE=4'b0011, AWPROT=0, AWQOS=0, AWUSER=0, WUSER=0, WSTRB=4'hf, BREADY=1.
REQ-015 The state machine SHALL have the states IDLE, AW, RD, W and B; the current state SHALL be a register.
REQ-016 In IDLE, START=1 SHALL latch AWADDR={PAGE_ADDR,12'b0}, clear the offset and ERR, set BUSY and go to AW.
REQ-017 START SHALL be ignored while BUSY=1.
REQ-018 AWVALID SHALL be 1 exactly while in AW.
REQ-019 In AW, AWREADY=1 SHALL move the state to RD; AWADDR and AWVALID SHALL be held stable until then.
REQ-020 BRAM_ADDR SHALL always equal the 12-bit byte offset register.
REQ-021 RD SHALL last exactly one cycle and then go to W; this covers the BRAM read latency.
REQ-022 In W: WVALID=1 and WDATA=BRAM_DOUT, both held stable until WREADY=1.
REQ-023 WLAST SHALL be 1 in W when offset[6:2]==5'd31.
REQ-024 On a W handshake: the offset SHALL increment by 4, modulo 4096.
- If WLAST=1, the next state SHALL be B.
- Otherwise the next state SHALL be RD.
REQ-025 In B, a BVALID=1 cycle SHALL be accepted. If BRESP!=2'b00, ERR SHALL be set.
- If the offset is 0 after wrapping (all 1024 words sent): go to IDLE, clear BUSY, pulse DONE for one cycle.
- Otherwise: AWADDR += 128 and go to AW.
REQ-026 Each page SHALL produce exactly 32 bursts of 32 beats, at AWADDR base+0, +128, ..., +3968, in ascending order; one burst SHALL be outstanding at a time.
REQ-027 W beats SHALL never be issued before the AW handshake of the same burst.
REQ-028 The next AW SHALL never be issued before the B response of the previous burst.
REQ-029 With a slave that is always ready, the steady-state W throughput SHALL be one beat per 2 cycles.
REQ-030 A BVALID outside state B SHALL be ignored; it SHALL not change the state or ERR.
REQ-031 START in the same cycle as DONE SHALL be ignored; BUSY is still 1 in that cycle.

Reset
REQ-032 RST SHALL force the state to IDLE and the following outputs to 0: AWADDR, offset (so BRAM_ADDR=0), AWVALID, WVALID, WLAST, BUSY, DONE, ERR.
REQ-033 RST in the middle of a page SHALL abort the page at the next edge with no DONE pulse. The partial DRAM content is undefined, and any later BVALID SHALL be ignored.

Verification
REQ-034 Ideal slave (AWREADY=WREADY=1, BVALID one cycle after WLAST, BRESP=0), START with PAGE_ADDR=20'h80001 -> AWADDRs 0x80001000 through 0x80001F80 in steps of 0x80; 1024 W beats; WDATA equals the BRAM word at BRAM_ADDR; 32 WLASTs; one DONE; ERR=0.
REQ-035 Back-pressure: WREADY toggles pseudo-randomly and AWREADY is delayed 0-5 cycles -> WDATA, WLAST and AWADDR stay stable while VALID is high without READY; the beat order and values are unchanged.
REQ-036 BRESP=2'b10 on burst 7 only -> ERR=1 from the burst-7 B cycle; all 32 bursts still complete; DONE pulses; the next START clears ERR.
REQ-037 START pulsed during burst 3 with a different PAGE_ADDR -> ignored; all AWADDRs keep the original page base.
REQ-038 RST asserted mid-W of burst 12 -> one cycle later AWVALID=WVALID=BUSY=0 and BRAM_ADDR=0; no DONE; a fresh START runs a full page correctly.

Source files
------------

// File: rtl/pagewb.sv
// Page write-back engine: streams one 4 KB BRAM page to DRAM as 32 AXI4 INCR bursts
// of 32 words, one burst outstanding at a time, with a sticky error flag for bad BRESPs.
module pagewb #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 1,
    parameter int C_M_AXI_BUSER_WIDTH     = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                START,
    input  logic [19:0]                         PAGE_ADDR,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                ERR,
    output logic [11:0]                         BRAM_ADDR,
    input  logic [31:0]                         BRAM_DOUT,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
    output logic [7:0]                          M_AXI_AWLEN,
    output logic [2:0]                          M_AXI_AWSIZE,
    output logic [1:0]                          M_AXI_AWBURST,
    output logic [1:0]                          M_AXI_AWLOCK,
    output logic [3:0]                          M_AXI_AWCACHE,
    output logic [2:0]                          M_AXI_AWPROT,
    output logic [3:0]                          M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]     M_AXI_AWUSER,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                                M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]      M_AXI_WUSER,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_BID,
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]      M_AXI_BUSER,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_RD   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t                          state_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
    logic [11:0]                     offset_r;
    logic                            awvalid_r;
    logic                            wvalid_r;
    logic                            wlast_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            err_r;
    logic                            unused_s;

    assign M_AXI_AWID    = {C_M_AXI_THREAD_ID_WIDTH{1'b0}};
    assign M_AXI_AWLEN   = 8'h1f;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 2'b00;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = {C_M_AXI_AWUSER_WIDTH{1'b0}};
    assign M_AXI_WUSER   = {C_M_AXI_WUSER_WIDTH{1'b0}};
    assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign M_AXI_BREADY  = 1'b1;

    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_WLAST   = wlast_r;
    // BRAM_ADDR is frozen during W, so the synchronous BRAM output stays stable as WDATA.
    assign M_AXI_WDATA   = BRAM_DOUT;
    assign BRAM_ADDR     = offset_r;
    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign ERR           = err_r;

    assign unused_s = &{1'b0, M_AXI_BID, M_AXI_BUSER};

    // Burst sequencer: AW -> (RD, W) x 32 -> B, repeated until the offset wraps to zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            awaddr_r  <= {C_M_AXI_ADDR_WIDTH{1'b0}};
            offset_r  <= 12'd0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            wlast_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // busy_r is still set during the DONE cycle, which blocks a START there.
                    if (START && !busy_r) begin
                        awaddr_r  <= C_M_AXI_ADDR_WIDTH'({PAGE_ADDR, 12'h000});
                        offset_r  <= 12'd0;
                        err_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        awvalid_r <= 1'b1;
                        state_r   <= S_AW;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_AW: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_r <= 1'b0;
                        state_r   <= S_RD;
                    end
                end
                S_RD: begin
                    wvalid_r <= 1'b1;
                    wlast_r  <= (offset_r[6:2] == 5'd31);
                    state_r  <= S_W;
                end
                S_W: begin
                    if (M_AXI_WREADY) begin
                        wvalid_r <= 1'b0;
                        wlast_r  <= 1'b0;
                        offset_r <= offset_r + 12'd4;
                        state_r  <= wlast_r ? S_B : S_RD;
                    end
                end
                S_B: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            err_r <= 1'b1;
                        end
                        if (offset_r == 12'd0) begin
                            done_r  <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            awaddr_r  <= awaddr_r + C_M_AXI_ADDR_WIDTH'(128);
                            awvalid_r <= 1'b1;
                            state_r   <= S_AW;
                        end
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    wlast_r   <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pagewb.sv
// Scoreboard bench for pagewb: expected AW addresses and W beats are queued at START,
// a monitor pops and compares them on every handshake.
module tb_pagewb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [19:0] PAGE_ADDR;
    logic        BUSY, DONE, ERR;
    logic [11:0] BRAM_ADDR;
    logic [31:0] BRAM_DOUT;
    logic [0:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic [1:0]  M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic [3:0]  M_AXI_AWQOS;
    logic [0:0]  M_AXI_AWUSER;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic [0:0]  M_AXI_WUSER;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [0:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic [0:0]  M_AXI_BUSER;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_aw [$];
    logic [32:0] exp_w [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_burst = -1;
    bit          bp_mode = 1'b0;
    bit          stray_en = 1'b0;

    always #5 CLK = ~CLK;

    pagewb dut (
        .CLK(CLK), .RST(RST), .START(START), .PAGE_ADDR(PAGE_ADDR),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    // Synchronous BRAM model: one cycle read latency.
    always @(posedge CLK) begin
        BRAM_DOUT <= mem[BRAM_ADDR[11:2]];
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_page(input logic [19:0] pg);
        for (int b = 0; b < 32; b++) exp_aw.push_back({pg, 12'h000} + 32'(b * 128));
        for (int k = 0; k < 1024; k++) exp_w.push_back({(k % 32 == 31), mem[k]});
    endtask

    task automatic pulse_start(input logic [19:0] pg);
        @(posedge CLK); #1;
        START = 1'b1;
        PAGE_ADDR = pg;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        check("done_timeout", seen, 1'b1);
    endtask

    // AXI slave: ready generation, BVALID one cycle after WLAST, optional stray BVALIDs.
    initial begin
        int aw_wait;
        logic hs_last;
        logic [4:0] bidx;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_BID = 1'b0; M_AXI_BUSER = 1'b0;
        aw_wait = 0;
        forever begin
            @(negedge CLK);
            hs_last = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST && !RST;
            bidx = M_AXI_AWADDR[11:7];
            @(posedge CLK); #1;
            if (hs_last) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP = (err_burst == int'(bidx)) ? 2'b10 : 2'b00;
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP = 2'b11;
            end else begin
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP = 2'b00;
            end
            if (!bp_mode) begin
                M_AXI_AWREADY = 1'b1;
                M_AXI_WREADY = 1'b1;
            end else begin
                M_AXI_WREADY = 1'($urandom_range(0, 1));
                if (!M_AXI_AWVALID) begin
                    M_AXI_AWREADY = 1'b0;
                    aw_wait = $urandom_range(0, 5);
                end else if (aw_wait == 0) begin
                    M_AXI_AWREADY = 1'b1;
                end else begin
                    M_AXI_AWREADY = 1'b0;
                    aw_wait--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on handshakes, checks stability, ordering and rate.
    initial begin
        logic [31:0] aw_hold, w_hold_d, e_aw;
        logic [32:0] e_w;
        logic w_hold_l;
        bit aw_wait_f, w_wait_f, burst_open, b_wait;
        int beat, last_w_cyc;
        aw_wait_f = 0; w_wait_f = 0; burst_open = 0; b_wait = 0; beat = 0; last_w_cyc = 0;
        aw_hold = '0; w_hold_d = '0; w_hold_l = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                aw_wait_f = 0; w_wait_f = 0; burst_open = 0; b_wait = 0;
            end else begin
                if (aw_wait_f && M_AXI_AWVALID) check("aw_stable", M_AXI_AWADDR, aw_hold);
                if (w_wait_f && M_AXI_WVALID) begin
                    check("wdata_stable", M_AXI_WDATA, w_hold_d);
                    check("wlast_stable", M_AXI_WLAST, w_hold_l);
                end
                if (b_wait && M_AXI_BVALID) begin
                    burst_open = 0;
                    b_wait = 0;
                end
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    check("aw_before_b", burst_open, 1'b0);
                    if (exp_aw.size() == 0) begin
                        check("aw_unexpected", M_AXI_AWADDR, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e_aw = exp_aw.pop_front();
                        check("awaddr", M_AXI_AWADDR, e_aw);
                        check("err_at_aw", ERR, (err_burst >= 0 && int'(e_aw[11:7]) > err_burst));
                    end
                    burst_open = 1;
                    beat = 0;
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    check("w_after_aw", burst_open, 1'b1);
                    if (exp_w.size() == 0) begin
                        check("w_unexpected", M_AXI_WDATA, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e_w = exp_w.pop_front();
                        check("wdata", M_AXI_WDATA, e_w[31:0]);
                        check("wlast", M_AXI_WLAST, e_w[32]);
                    end
                    if (!bp_mode && beat > 0) check("w_rate", cyc - last_w_cyc, 2);
                    last_w_cyc = cyc;
                    beat++;
                    if (M_AXI_WLAST) b_wait = 1;
                end
                if (DONE) begin
                    done_cnt++;
                    check("busy_at_done", BUSY, 1'b1);
                end
                aw_wait_f = M_AXI_AWVALID && !M_AXI_AWREADY;
                aw_hold = M_AXI_AWADDR;
                w_wait_f = M_AXI_WVALID && !M_AXI_WREADY;
                w_hold_d = M_AXI_WDATA;
                w_hold_l = M_AXI_WLAST;
            end
        end
    end

    // Directed sequence of pages.
    initial begin
        bit found;
        int d0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
        RST = 1'b1; START = 1'b0; PAGE_ADDR = 20'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_awvalid", M_AXI_AWVALID, 1'b0);
        check("rst_wvalid", M_AXI_WVALID, 1'b0);
        check("rst_wlast", M_AXI_WLAST, 1'b0);
        check("rst_awaddr", M_AXI_AWADDR, 32'h0);
        check("rst_bram_addr", BRAM_ADDR, 12'h0);
        check("const_aw", {M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
                           M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER},
              {1'b0, 8'h1f, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 1'b0});
        check("const_w_b", {M_AXI_WUSER, M_AXI_WSTRB, M_AXI_BREADY}, {1'b0, 4'hf, 1'b1});
        @(posedge CLK); #1;
        RST = 1'b0;

        // Ideal slave, plus a START in the DONE cycle that must be ignored.
        push_page(20'h80001);
        pulse_start(20'h80001);
        check("start_busy", BUSY, 1'b1);
        check("start_awvalid", M_AXI_AWVALID, 1'b1);
        check("start_awaddr", M_AXI_AWADDR, 32'h8000_1000);
        wait_done(5000);
        START = 1'b1;
        PAGE_ADDR = 20'h00777;
        check("p1_err", ERR, 1'b0);
        check("p1_aw_left", exp_aw.size(), 0);
        check("p1_w_left", exp_w.size(), 0);
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("start_at_done_busy", BUSY, 1'b0);
        check("start_at_done_awvalid", M_AXI_AWVALID, 1'b0);

        // Back-pressure with stray BVALIDs outside B.
        bp_mode = 1'b1;
        stray_en = 1'b1;
        push_page(20'h12345);
        pulse_start(20'h12345);
        wait_done(20000);
        check("bp_err", ERR, 1'b0);
        check("bp_aw_left", exp_aw.size(), 0);
        check("bp_w_left", exp_w.size(), 0);
        bp_mode = 1'b0;
        stray_en = 1'b0;
        repeat (3) @(posedge CLK);

        // SLVERR on burst 7 only.
        err_burst = 7;
        push_page(20'h00ABC);
        pulse_start(20'h00ABC);
        wait_done(5000);
        check("err_sticky", ERR, 1'b1);
        check("err_aw_left", exp_aw.size(), 0);
        err_burst = -1;
        repeat (3) @(posedge CLK);

        // START during burst 3 with another page is ignored.
        push_page(20'h00010);
        pulse_start(20'h00010);
        check("err_cleared", ERR, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge CLK);
            if (M_AXI_AWVALID && M_AXI_AWADDR[11:7] == 5'd3) found = 1'b1;
        end
        check("burst3_timeout", found, 1'b1);
        START = 1'b1;
        PAGE_ADDR = 20'hFFFFF;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done(5000);
        check("ign_aw_left", exp_aw.size(), 0);
        check("ign_w_left", exp_w.size(), 0);

        // Reset in the middle of burst 12, then a clean page.
        push_page(20'h55555);
        pulse_start(20'h55555);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge CLK);
            if (M_AXI_WVALID && M_AXI_AWADDR[11:7] == 5'd12 && BRAM_ADDR[6:2] == 5'd10) found = 1'b1;
        end
        check("burst12_timeout", found, 1'b1);
        d0 = done_cnt;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort_awvalid", M_AXI_AWVALID, 1'b0);
        check("abort_wvalid", M_AXI_WVALID, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_bram_addr", BRAM_ADDR, 12'h0);
        check("abort_done", DONE, 1'b0);
        exp_aw.delete();
        exp_w.delete();
        repeat (4) @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_no_done", done_cnt, d0);
        push_page(20'h55555);
        pulse_start(20'h55555);
        wait_done(5000);
        check("rerun_aw_left", exp_aw.size(), 0);
        check("rerun_w_left", exp_w.size(), 0);
        check("rerun_err", ERR, 1'b0);
        repeat (3) @(negedge CLK);
        check("done_total", done_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
